// File: rtl/spi_slave_stream_if.sv
// spi_slave_stream_if: fabric-side TX/RX word streams and error pulses of spi_slave_stream.
interface spi_slave_stream_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             tx_underrun;
  logic             rx_overrun;
  logic             frame_error;
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, frame_error
  );
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, frame_error
  );
endinterface

// File: rtl/spi_slave_stream.sv
// spi_slave_stream: oversampling SPI slave, all CPOL/CPHA modes, multi-word frames, stream handshakes.
module spi_slave_stream #(
  parameter int               WIDTH     = 32,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter bit               LSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ucSCLK,
  input  logic ucMOSI,
  input  logic ucSEL_,
  output logic ucMISO,
  output logic ucMISO_oe,
  spi_slave_stream_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, sel_q;
  logic [1:0] mosi_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d, done_q, done_d;
  logic underrun_q, underrun_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic sel_fall, sel_rise, lead, trail, sample, shift, last, load;
  assign sel_fall = sel_q[2] & ~sel_q[1];
  assign sel_rise = ~sel_q[2] & sel_q[1];
  assign lead     = (sclk_q[2] ^ sclk_q[1]) & (sclk_q[2] == CPOL);
  assign trail    = (sclk_q[2] ^ sclk_q[1]) & (sclk_q[2] != CPOL);
  assign sample   = CPHA ? trail : lead;
  assign shift    = CPHA ? lead : trail;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    ferr_d     = 1'b0;
    last       = 1'b0;
    load       = 1'b0;
    if (s.tx_valid && tx_ready_q) begin
      tx_buf_d   = s.tx_data;
      tx_ready_d = 1'b0;
    end
    if (rx_valid_q && s.rx_ready) rx_valid_d = 1'b0;
    if (done_q) begin
      if (rx_valid_q && !s.rx_ready) overrun_d = 1'b1;
      else begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end
    end
    if (state_q == IDLE) begin
      if (sel_fall) begin
        state_d   = ACTIVE;
        bit_cnt_d = '0;
        load      = !CPHA;
      end
    end else if (sel_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      ferr_d    = bit_cnt_q != '0;
    end else begin
      if (sample) begin
        rx_sh_d   = LSB_FIRST ? {mosi_q[1], rx_sh_q[WIDTH-1:1]} : {rx_sh_q[WIDTH-2:0], mosi_q[1]};
        last      = bit_cnt_q == CW'(WIDTH - 1);
        bit_cnt_d = last ? '0 : bit_cnt_q + CW'(1);
        done_d    = last;
        load      = last && !CPHA;
      end
      // The shift edge right after a CPHA=0 reload would skip bit 0 of the new word.
      if (shift) begin
        if (CPHA && bit_cnt_q == '0) load = 1'b1;
        else if (CPHA || bit_cnt_q != '0) tx_sh_d = LSB_FIRST ? tx_sh_q >> 1 : tx_sh_q << 1;
      end
    end
    if (load) begin
      tx_sh_d    = tx_ready_q ? IDLE_WORD : tx_buf_q;
      underrun_d = tx_ready_q;
      if (!tx_ready_q) tx_ready_d = 1'b1;
    end
  end
  // SEL sync resets to "selected" so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= {3{CPOL}};
      sel_q      <= 3'b000;
      mosi_q     <= 2'b00;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[1:0], ucSCLK};
      sel_q      <= {sel_q[1:0], ucSEL_};
      mosi_q     <= {mosi_q[0], ucMOSI};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end
  assign ucMISO_oe     = state_q == ACTIVE;
  assign ucMISO        = ucMISO_oe & (LSB_FIRST ? tx_sh_q[0] : tx_sh_q[WIDTH-1]);
  assign s.tx_ready    = tx_ready_q;
  assign s.rx_data     = rx_data_q;
  assign s.rx_valid    = rx_valid_q;
  assign s.tx_underrun = underrun_q;
  assign s.rx_overrun  = overrun_q;
  assign s.frame_error = ferr_q;
endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream: directed checks of four 8-bit instances (mode 0 MSB-first, modes 1/2/3 LSB-first).
module tb_spi_slave_stream;
  localparam int H = 80;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];
  logic tx_valid [4], tx_ready [4], rx_valid [4], rx_ready [4];
  logic und_p [4], ovr_p [4], fe_p [4];
  logic sclk [4], sel [4], mosi [4], miso [4], oe [4];
  int und [4], ovr [4], fe [4];
  logic [7:0] rxq [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : m
    spi_slave_stream_if #(.WIDTH(8)) bus ();
    spi_slave_stream #(
      .WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .LSB_FIRST(g != 0), .IDLE_WORD(8'hFF)
    ) dut (
      .clk(clk), .rst_n(rst_n), .ucSCLK(sclk[g]), .ucMOSI(mosi[g]), .ucSEL_(sel[g]),
      .ucMISO(miso[g]), .ucMISO_oe(oe[g]), .s(bus)
    );
    assign bus.tx_data  = tx_data[g];
    assign bus.tx_valid = tx_valid[g];
    assign bus.rx_ready = rx_ready[g];
    assign tx_ready[g]  = bus.tx_ready;
    assign rx_data[g]   = bus.rx_data;
    assign rx_valid[g]  = bus.rx_valid;
    assign und_p[g]     = bus.tx_underrun;
    assign ovr_p[g]     = bus.rx_overrun;
    assign fe_p[g]      = bus.frame_error;
  end
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (und_p[k]) und[k]++;
      if (ovr_p[k]) ovr[k]++;
      if (fe_p[k]) fe[k]++;
    end
    if (rx_valid[0] && rx_ready[0]) rxq.push_back(rx_data[0]);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int n, input logic [7:0] w);
    tx_data[n] = w;
    tx_valid[n] = 1'b1;
    #10;
    tx_valid[n] = 1'b0;
  endtask
  // SPI master: drives nb bits of w and returns what it sampled on MISO.
  task automatic word(input int n, input logic [7:0] w, input int nb, output logic [7:0] got);
    logic pol, ph, lsb;
    pol = n >= 2;
    ph  = n % 2 == 1;
    lsb = n != 0;
    got = '0;
    for (int k = 0; k < nb; k++) begin
      int b;
      b = lsb ? k : 7 - k;
      if (!ph) begin
        mosi[n] = w[b];
        #H;
        sclk[n] = ~pol;
        got[b] = miso[n];
        #H;
        sclk[n] = pol;
      end else begin
        sclk[n] = ~pol;
        mosi[n] = w[b];
        #H;
        sclk[n] = pol;
        got[b] = miso[n];
        #H;
      end
    end
  endtask
  initial begin
    logic [7:0] g1, g2, g3;
    int u0, o0, f0;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sclk[k] = k >= 2;
      sel[k] = 1'b1;
      mosi[k] = 1'b0;
      tx_data[k] = '0;
      tx_valid[k] = 1'b0;
      rx_ready[k] = 1'b0;
      und[k] = 0;
      ovr[k] = 0;
      fe[k] = 0;
    end
    #30 rst_n = 1'b1;
    #20;
    chk("reset tx_ready", tx_ready[0], 1);
    chk("reset rx_valid", rx_valid[0], 0);
    chk("reset rx_data", rx_data[0], 0);
    chk("reset oe", oe[0], 0);
    chk("reset miso", miso[0], 0);
    // Mode 0 MSB-first single word; a second TX word is queued so the end-of-word reload is not an underrun.
    push(0, 8'hA5);
    chk("m0 tx_ready after push", tx_ready[0], 0);
    sel[0] = 1'b0;
    #H;
    chk("m0 oe selected", oe[0], 1);
    push(0, 8'h5A);
    word(0, 8'h3C, 8, g1);
    #H sel[0] = 1'b1;
    #H;
    chk("m0 miso word", g1, 8'hA5);
    chk("m0 rx_data", rx_data[0], 8'h3C);
    chk("m0 rx_valid", rx_valid[0], 1);
    chk("m0 underrun", und[0], 0);
    chk("m0 overrun", ovr[0], 0);
    chk("m0 frame_error", fe[0], 0);
    chk("m0 oe deselected", oe[0], 0);
    rx_ready[0] = 1'b1;
    #10 rx_ready[0] = 1'b0;
    #10;
    chk("m0 rx_valid popped", rx_valid[0], 0);
    // Modes 1/2/3, LSB-first.
    for (int n = 1; n < 4; n++) begin
      push(n, 8'h81);
      sel[n] = 1'b0;
      #H;
      word(n, 8'h12, 8, g1);
      #H sel[n] = 1'b1;
      #H;
      chk($sformatf("m%0d miso word", n), g1, 8'h81);
      chk($sformatf("m%0d rx_data", n), rx_data[n], 8'h12);
      chk($sformatf("m%0d rx_valid", n), rx_valid[n], 1);
      chk($sformatf("m%0d frame_error", n), fe[n], 0);
    end
    chk("m1 underrun", und[1], 0);
    chk("m2 end-of-word reload underrun", und[2], 1);
    // Multi-word frame in mode 0; second TX word arrives after word 2 was already loaded.
    rxq.delete();
    rx_ready[0] = 1'b1;
    u0 = und[0];
    push(0, 8'hAA);
    sel[0] = 1'b0;
    #H;
    word(0, 8'h11, 8, g1);
    push(0, 8'hBB);
    word(0, 8'h22, 8, g2);
    chk("mw underrun after word2", und[0] - u0, 1);
    word(0, 8'h33, 8, g3);
    #H sel[0] = 1'b1;
    #H;
    rx_ready[0] = 1'b0;
    chk("mw miso word1", g1, 8'hAA);
    chk("mw miso word2", g2, 8'hFF);
    chk("mw miso word3", g3, 8'hBB);
    chk("mw rx count", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("mw rx word1", rxq[0], 8'h11);
      chk("mw rx word2", rxq[1], 8'h22);
      chk("mw rx word3", rxq[2], 8'h33);
    end
    chk("mw frame_error", fe[0], 0);
    // Overrun: two words with rx_ready low.
    o0 = ovr[0];
    sel[0] = 1'b0;
    #H;
    word(0, 8'h44, 8, g1);
    word(0, 8'h55, 8, g1);
    #H sel[0] = 1'b1;
    #H;
    chk("ovr rx_data kept", rx_data[0], 8'h44);
    chk("ovr rx_valid", rx_valid[0], 1);
    chk("ovr pulse count", ovr[0] - o0, 1);
    rx_ready[0] = 1'b1;
    #20;
    chk("ovr rx_valid dropped", rx_valid[0], 0);
    rx_ready[0] = 1'b0;
    // Abort after 5 of 8 bits.
    f0 = fe[0];
    sel[0] = 1'b0;
    #H;
    word(0, 8'h77, 5, g1);
    #H sel[0] = 1'b1;
    #H;
    chk("abort frame_error", fe[0] - f0, 1);
    chk("abort rx_valid", rx_valid[0], 0);
    chk("abort oe", oe[0], 0);
    // Reset pulsed mid-word; the rest of that frame must be ignored.
    f0 = fe[0];
    push(0, 8'hC3);
    sel[0] = 1'b0;
    #H;
    word(0, 8'hF0, 3, g1);
    rst_n = 1'b0;
    #20;
    chk("rst tx_ready", tx_ready[0], 1);
    chk("rst oe", oe[0], 0);
    chk("rst miso", miso[0], 0);
    chk("rst rx_valid", rx_valid[0], 0);
    chk("rst rx_data", rx_data[0], 0);
    rst_n = 1'b1;
    #20;
    word(0, 8'hF0, 5, g1);
    #H sel[0] = 1'b1;
    #H;
    chk("post-rst ignored rx_valid", rx_valid[0], 0);
    chk("post-rst ignored frame_error", fe[0] - f0, 0);
    push(0, 8'h96);
    sel[0] = 1'b0;
    #H;
    word(0, 8'h69, 8, g1);
    #H sel[0] = 1'b1;
    #H;
    chk("post-rst miso word", g1, 8'h96);
    chk("post-rst rx_data", rx_data[0], 8'h69);
    chk("post-rst rx_valid", rx_valid[0], 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_stream.md
Name:
spi_slave_stream

Overview:
- Parametrised successor to the icestick single-word SPI slave.
- Supports all four SPI modes (CPOL/CPHA), MSB- or LSB-first order and multi-word frames, where every WIDTH bits under one ucSEL_ assertion form a word.
- Exposes valid/ready TX and RX streams to fabric logic in place of the bare data_in/data_out pair, and flags underrun, overrun and partial-word errors.
- Sits between the microcontroller SPI pins and on-chip register/FIFO logic, single clk domain.

Parameters:
- WIDTH, 32, bits per word (>=2).
- CPOL, 0, idle level of ucSCLK.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
- LSB_FIRST, 0, 1 = shift LSB first on both MOSI and MISO.
- IDLE_WORD, all-ones, word transmitted when no TX word is buffered.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ucSCLK  in  1  SPI clock from master, asynchronous.
- ucMOSI  in  1  master-out data, asynchronous.
- ucSEL_  in  1  active-low chip select, asynchronous.
- ucMISO  out  1  slave-out data; 0 when ucMISO_oe=0.
- ucMISO_oe  out  1  tri-state enable for the MISO pad; high while selected.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-word TX buffer empty.
- rx_data  out  WIDTH  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- tx_underrun  out  1  1-cycle pulse when IDLE_WORD is loaded instead of a buffered word.
- rx_overrun  out  1  1-cycle pulse when a completed word is dropped.
- frame_error  out  1  1-cycle pulse when ucSEL_ deasserts mid-word.

Behaviour:
- Synchronisers:
  - ucSCLK and ucSEL_ pass through 3-flop shift registers; edges are detected on stages [2:1].
  - ucMOSI passes through 2 flops.
  - The SCLK edge is gated by selected state.
  - ucSCLK must be <= clk/8.
- Edge roles: leading edge = transition away from CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other edge.
- Reset values:
  - State IDLE; bit_cnt=0; shifter=0.
  - ucMISO=0, ucMISO_oe=0.
  - tx_ready=1; rx_valid=0; rx_data=0.
  - All pulses 0.
- FSM states: IDLE and ACTIVE.
- IDLE -> ACTIVE on detected ucSEL_ fall.
  - ucMISO_oe goes 1.
  - bit_cnt=0.
  - If CPHA=0, the first word is loaded into the shifter in the same cycle.
- ACTIVE -> IDLE on detected ucSEL_ rise.
  - ucMISO_oe goes 0.
  - If bit_cnt!=0, pulse frame_error and discard the partial word.
  - No rx_valid is raised for a partial word.
- Word load: takes the TX buffer if full (tx_ready then returns to 1 next cycle), else IDLE_WORD with a tx_underrun pulse.
  - CPHA=0: load at SEL fall and in the cycle the WIDTH-th sample completes while still selected.
  - CPHA=1: load at the first shift (leading) edge of each word, when bit_cnt=0.
- Sample edge: shift in synced MOSI (MSB-first: into bit 0 with left shift; LSB-first: into bit WIDTH-1 with right shift) and increment bit_cnt.
  - At bit_cnt=WIDTH-1, wrap to 0 and complete the word.
- Shift edge: advance the MISO bit.
  - ucMISO = shifter[WIDTH-1] if MSB-first, shifter[0] if LSB-first.
  - CPHA=0: bit k+1 appears after trailing edge k.
  - CPHA=1: bit k appears after leading edge k; that edge loads rather than shifts when bit_cnt=0.
- RX completion: rx_data and rx_valid are updated 1 clk after the detected final sample edge.
  - If rx_valid=1 and rx_ready=0 in that cycle: keep old rx_data, pulse rx_overrun.
  - If rx_valid=1 and rx_ready=1 in that cycle: pop and replace; rx_valid stays 1; no overrun.
- RX handshake: rx_valid & rx_ready clears rx_valid next cycle.
- TX handshake:
  - tx_valid & tx_ready captures tx_data; tx_ready=0 next cycle.
  - If a capture coincides with a load from an empty buffer, the load uses IDLE_WORD (underrun) and the captured word waits for the next word.
- rst_n low mid-frame aborts immediately to reset values.
  - After release, the block ignores the frame until the next ucSEL_ fall.

Test Plan:
- Mode 0, MSB-first, WIDTH=8:
  - Stimulus: preload tx 0xA5; master sends 0x3C in one frame.
  - Required: MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid; no pulses.
- Modes 1/2/3, each with LSB_FIRST=1:
  - Stimulus: tx 0x81; master sends 0x12.
  - Required: master captures 0x81; rx_data=0x12 in all modes.
- Multi-word frame, 3 words (0x11, 0x22, 0x33):
  - Stimulus: tx 0xAA preloaded; second TX word supplied late.
  - Required: MISO 0xAA then 0xFF with tx_underrun pulse; with rx_ready=1 always, three rx words 0x11/0x22/0x33.
- Overrun:
  - Stimulus: rx_ready=0; two words received.
  - Required: rx_data=first word, one rx_overrun pulse; after rx_ready=1, rx_valid drops.
- Abort:
  - Stimulus: ucSEL_ rises after 5 of 8 bits.
  - Required: frame_error pulse, no rx_valid, ucMISO_oe=0.
  - Stimulus: rst_n pulsed low mid-word.
  - Required: all outputs return to reset values; next frame works normally.
